// File: rtl/pic_pkg.sv
// Shared interrupt-controller definitions: OCW2 command encodings and
// one-hot/index helpers sized for the largest supported level count.
package pic_pkg;

  localparam int MAX_LEVELS  = 64;
  localparam int MAX_LEVEL_W = 6;

  typedef enum logic [2:0] {
    OCW2_CLEAR_ROTATE   = 3'b000,
    OCW2_NONSPEC_EOI    = 3'b001,
    OCW2_NOP            = 3'b010,
    OCW2_SPEC_EOI       = 3'b011,
    OCW2_SET_ROTATE     = 3'b100,
    OCW2_ROTATE_NONSPEC = 3'b101,
    OCW2_SET_PRIORITY   = 3'b110,
    OCW2_ROTATE_SPEC    = 3'b111
  } ocw2_cmd_e;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [MAX_LEVEL_W-1:0] lowest_index(input logic [MAX_LEVELS-1:0] vec);
    lowest_index = '0;
    for (int i = MAX_LEVELS - 1; i >= 0; i--) begin
      if (vec[i]) lowest_index = MAX_LEVEL_W'(i);
    end
  endfunction

  function automatic logic [MAX_LEVELS-1:0] index_to_onehot(input logic [MAX_LEVEL_W-1:0] idx);
    index_to_onehot = MAX_LEVELS'(1) << idx;
  endfunction

endpackage

// File: rtl/priority_rotate_resolver.sv
// Picks the highest-priority request under rotating priority: level
// lowest_level+1 wins first, ascending with wrap, lowest_level last.
module priority_rotate_resolver #(
  parameter int NUM_LEVELS = 8,
  parameter int LEVEL_W    = $clog2(NUM_LEVELS)
) (
  input  logic [NUM_LEVELS-1:0] request,
  input  logic [LEVEL_W-1:0]    lowest_level,
  output logic [NUM_LEVELS-1:0] grant
);

  logic [NUM_LEVELS-1:0] rotated;
  logic [NUM_LEVELS-1:0] rot_grant;
  logic [LEVEL_W-1:0]    src_idx;

  // Index wrap comes for free from the LEVEL_W-bit truncation (power-of-two levels).
  always_comb begin
    rotated = '0;
    grant   = '0;
    src_idx = '0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      src_idx    = LEVEL_W'(i) + lowest_level + LEVEL_W'(1);
      rotated[i] = request[src_idx];
    end
    rot_grant = rotated & (~rotated + NUM_LEVELS'(1));
    for (int i = 0; i < NUM_LEVELS; i++) begin
      src_idx        = LEVEL_W'(i) + lowest_level + LEVEL_W'(1);
      grant[src_idx] = rot_grant[i];
    end
  end

endmodule

// File: rtl/eoi_rotation_controller.sv
// In-service register, EOI handling and priority rotation for an
// 8259-style interrupt controller.
module eoi_rotation_controller
  import pic_pkg::*;
#(
  parameter int NUM_LEVELS = 8,
  parameter int LEVEL_W    = $clog2(NUM_LEVELS)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  write_initial_command_word_1,
  input  logic                  auto_eoi_config,
  input  logic                  acknowledge_start,
  input  logic                  end_of_acknowledge_sequence,
  input  logic [NUM_LEVELS-1:0] acknowledge_interrupt,
  input  logic                  write_operation_control_word_2,
  input  logic [2:0]            ocw2_command,
  input  logic [LEVEL_W-1:0]    ocw2_level,
  output logic [NUM_LEVELS-1:0] in_service,
  output logic [NUM_LEVELS-1:0] highest_level_in_service,
  output logic [NUM_LEVELS-1:0] end_of_interrupt,
  output logic [LEVEL_W-1:0]    priority_rotate,
  output logic                  auto_rotate_mode,
  output logic                  eoi_error
);

  logic [NUM_LEVELS-1:0] isr_q, isr_d;
  logic [NUM_LEVELS-1:0] eoi_q, eoi_d;
  logic [LEVEL_W-1:0]    pr_q, pr_d;
  logic                  arm_q, arm_d;
  logic                  err_q, err_d;

  logic [NUM_LEVELS-1:0] hlis;
  logic [NUM_LEVELS-1:0] spec_mask;
  logic [NUM_LEVELS-1:0] clear_mask;
  logic [NUM_LEVELS-1:0] set_mask;
  logic                  aeoi_clear;
  logic                  ocw2_valid;

  priority_rotate_resolver #(
    .NUM_LEVELS (NUM_LEVELS),
    .LEVEL_W    (LEVEL_W)
  ) u_resolver (
    .request      (isr_q),
    .lowest_level (pr_q),
    .grant        (hlis)
  );

  always_comb begin
    aeoi_clear = end_of_acknowledge_sequence & auto_eoi_config & ~write_initial_command_word_1;
    ocw2_valid = write_operation_control_word_2 & ~write_initial_command_word_1 & ~aeoi_clear;
    spec_mask  = NUM_LEVELS'(index_to_onehot(MAX_LEVEL_W'(ocw2_level)));
    clear_mask = '0;
    set_mask   = '0;
    pr_d       = pr_q;
    arm_d      = arm_q;
    err_d      = 1'b0;

    if (write_initial_command_word_1) begin
      clear_mask = '1;
      pr_d       = LEVEL_W'(NUM_LEVELS - 1);
      arm_d      = 1'b0;
    end else begin
      if (acknowledge_start) set_mask = acknowledge_interrupt;
      if (aeoi_clear) begin
        clear_mask = acknowledge_interrupt & isr_q;
        if (arm_q && |acknowledge_interrupt)
          pr_d = LEVEL_W'(lowest_index(MAX_LEVELS'(acknowledge_interrupt)));
      end else if (ocw2_valid) begin
        case (ocw2_cmd_e'(ocw2_command))
          OCW2_NONSPEC_EOI, OCW2_ROTATE_NONSPEC: clear_mask = hlis;
          OCW2_SPEC_EOI, OCW2_ROTATE_SPEC:       clear_mask = spec_mask & isr_q;
          OCW2_SET_PRIORITY:                     pr_d = ocw2_level;
          OCW2_SET_ROTATE:                       arm_d = 1'b1;
          OCW2_CLEAR_ROTATE:                     arm_d = 1'b0;
          default: ;
        endcase
        // Bit 0 marks every EOI-type command; bit 2 marks the rotating ones.
        if (ocw2_command[0]) begin
          if (clear_mask == '0)
            err_d = 1'b1;
          else if (ocw2_command[2])
            pr_d = LEVEL_W'(lowest_index(MAX_LEVELS'(clear_mask)));
        end
      end
    end

    isr_d = (isr_q & ~clear_mask) | set_mask;
    eoi_d = write_initial_command_word_1 ? '1 : (isr_q & clear_mask);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      isr_q <= '0;
      eoi_q <= '0;
      pr_q  <= LEVEL_W'(NUM_LEVELS - 1);
      arm_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      isr_q <= isr_d;
      eoi_q <= eoi_d;
      pr_q  <= pr_d;
      arm_q <= arm_d;
      err_q <= err_d;
    end
  end

  assign in_service               = isr_q;
  assign highest_level_in_service = hlis;
  assign end_of_interrupt         = eoi_q;
  assign priority_rotate          = pr_q;
  assign auto_rotate_mode         = arm_q;
  assign eoi_error                = err_q;

endmodule
